// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: funct3, error-code and FSM encodings shared by the RV32I load/store unit
package rv_lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    // Illegal encodings win over misalignment, so a bad op never reports as misaligned.
    function automatic logic [1:0] access_check(input logic ld, input logic st,
                                                input logic [2:0] f3, input logic [1:0] a);
        logic illegal, misaligned;
        illegal    = (ld == st) || (ld && (f3 == 3'b011 || f3[2:1] == 2'b11)) || (st && f3 > F3_W);
        misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return illegal ? ERR_ILLEGAL : misaligned ? ERR_MISALIGN : ERR_NONE;
    endfunction
endpackage

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: byte enables, store lane replication and load extract/extend for one word
module rv_lsu_align
    import rv_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteen,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  rd_b;
    logic [15:0] rd_h;

    assign byteen    = funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
                       funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_rep = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                       funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    assign rd_b      = 8'(rdata >> {addr_lo, 3'b000});
    assign rd_h      = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign rdata_ext = funct3 == F3_B  ? {{24{rd_b[7]}}, rd_b} :
                       funct3 == F3_H  ? {{16{rd_h[15]}}, rd_h} :
                       funct3 == F3_BU ? {24'b0, rd_b} :
                       funct3 == F3_HU ? {16'b0, rd_h} : rdata;
endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: RV32I load/store unit bridging the execute stage to a word-wide memory port
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 11
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_err,
    output logic [1:0]        lsu_err_code,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byteen,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_wait,
    input  logic              mem_rdata_valid,
    input  logic [31:0]       mem_rdata
);
    logic [1:0]        state;
    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        f3_q;
    logic              load_q;
    logic [31:0]       wdata_q, rdata_q, rdata_ext, wdata_rep;
    logic [1:0]        err_q, cap_err;
    logic [TO_W-1:0]   to_cnt;
    logic [3:0]        byteen;
    logic              req, to_hit, unused_addr;

    assign cap_err      = access_check(ex_load, ex_store, ex_funct3, ex_addr[1:0]);
    assign req          = state == S_REQ;
    assign to_hit       = TIMEOUT_CYC != 0 && to_cnt == TO_W'(TIMEOUT_CYC - 1);
    assign unused_addr  = ^ex_addr[31:ADDR_W+2];
    assign lsu_busy     = req || state == S_WAIT_RD;
    assign lsu_done     = state == S_RESP;
    assign lsu_rdata    = rdata_q;
    assign lsu_err      = lsu_done && err_q != ERR_NONE;
    assign lsu_err_code = lsu_done ? err_q : ERR_NONE;
    assign mem_addr     = req ? addr_q[ADDR_W+1:2] : '0;
    assign mem_wdata    = req ? wdata_rep : '0;
    assign mem_byteen   = req ? byteen : '0;
    assign mem_read     = req && load_q;
    assign mem_write    = req && !load_q;

    rv_lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .byteen    (byteen),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // rdata_q only changes on the way into RESP so it holds between completions.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            load_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
            to_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (ex_valid) begin
                    addr_q  <= ex_addr[ADDR_W+1:0];
                    f3_q    <= ex_funct3;
                    load_q  <= ex_load;
                    wdata_q <= ex_wdata;
                    err_q   <= cap_err;
                    to_cnt  <= '0;
                    state   <= cap_err == ERR_NONE ? S_REQ : S_RESP;
                    if (cap_err != ERR_NONE) rdata_q <= '0;
                end
                S_REQ: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (!mem_wait && !load_q) begin
                        state   <= S_RESP;
                        rdata_q <= '0;
                    end else if (to_hit) begin
                        state   <= S_RESP;
                        err_q   <= ERR_TIMEOUT;
                        rdata_q <= '0;
                    end else if (!mem_wait) begin
                        state <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (mem_rdata_valid) begin
                        state   <= S_RESP;
                        rdata_q <= rdata_ext;
                    end else if (to_hit) begin
                        state   <= S_RESP;
                        err_q   <= ERR_TIMEOUT;
                        rdata_q <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed plus randomized checks of rv_lsu against an arithmetic reference model
module tb_rv_lsu;
    logic        iCLK = 1'b0, iRST_n = 1'b0;
    logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic        lsu_busy, lsu_done, lsu_err, mem_read, mem_write;
    logic [31:0] lsu_rdata, mem_wdata;
    logic [1:0]  lsu_err_code;
    logic [27:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic        mem_wait = 1'b0, mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          checks = 0, failures = 0;

    rv_lsu #(.ADDR_W(28), .TIMEOUT_CYC(8), .TO_W(4)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .lsu_busy(lsu_busy),
        .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err), .lsu_err_code(lsu_err_code),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wait(mem_wait), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [1:0] ref_err(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
        if (ld == st) return 2'd2;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'd2;
        if (st && f3 > 3'd2) return 2'd2;
        if (int'(a[1:0]) % nbytes(f3) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        int n = nbytes(f3);
        logic [31:0] v;
        if (n == 4) return r;
        v = (r >> (8 * int'(a[1:0]))) & ((32'd1 << (8 * n)) - 32'd1);
        if (f3 < 3'd4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
        int n = nbytes(f3);
        return n == 1 ? 32'(w[7:0]) * 32'h01010101 : n == 2 ? 32'(w[15:0]) * 32'h00010001 : w;
    endfunction

    task automatic access(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] r, input int wait_n, input int rd_dly);
        logic [1:0]  e;
        logic [31:0] exp_r;
        int          n;
        e     = ref_err(ld, st, f3, a);
        n     = nbytes(f3);
        exp_r = (e == 2'd0 && ld) ? ref_load(f3, a, r) : 32'd0;
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3; ex_addr = a; ex_wdata = w;
        step();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_wdata = $urandom;
        if (e != 2'd0) begin
            chk("err_noreq", 32'({mem_read, mem_write}), 32'd0);
            chk("err_busy", 32'(lsu_busy), 32'd0);
        end else begin
            for (int k = 0; k <= wait_n; k++) begin
                chk("req_busy", 32'(lsu_busy), 32'd1);
                chk("req_rw", 32'({mem_read, mem_write}), 32'({ld, st}));
                chk("req_addr", 32'(mem_addr), 32'(a[29:2]));
                chk("req_be", 32'(mem_byteen), 32'(((1 << n) - 1) << a[1:0]) & 32'hF);
                if (st) chk("req_wdata", mem_wdata, ref_wdata(f3, w));
                mem_wait = (k < wait_n);
                step();
            end
            mem_wait = 1'b0;
            if (ld) begin
                for (int k = 0; k < rd_dly; k++) begin
                    chk("rd_wait", 32'({lsu_done, mem_read, lsu_busy}), 32'b001);
                    step();
                end
                mem_rdata_valid = 1'b1; mem_rdata = r;
                step();
                mem_rdata_valid = 1'b0; mem_rdata = $urandom;
            end
        end
        chk("done", 32'(lsu_done), 32'd1);
        chk("err_code", 32'(lsu_err_code), 32'(e));
        chk("err_flag", 32'(lsu_err), 32'(e != 2'd0));
        chk("rdata", lsu_rdata, exp_r);
        step();
        chk("done_pulse", 32'({lsu_done, lsu_busy}), 32'd0);
        chk("rdata_hold", lsu_rdata, exp_r);
    endtask

    initial begin
        int n, sel;
        logic ld, st;
        logic [31:0] a;
        step(); step();
        chk("rst_outs", 32'({lsu_busy, lsu_done, lsu_err, mem_read, mem_write}), 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_mem", 32'(mem_addr) | mem_wdata | 32'(mem_byteen) | 32'(lsu_err_code), 32'd0);
        iRST_n = 1'b1;
        step();
        access(1'b0, 1'b1, 3'd0, 32'h103, 32'hAB, 32'h0, 0, 0);
        access(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h0080_0000, 0, 0);
        access(1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 32'h0080_0000, 0, 1);
        access(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'hBEEF_0000, 1, 2);
        access(1'b1, 1'b0, 3'd2, 32'h202, 32'h0, 32'h0, 0, 0);
        access(1'b0, 1'b1, 3'd1, 32'h001, 32'h1234, 32'h0, 0, 0);
        access(1'b1, 1'b1, 3'd2, 32'h100, 32'h0, 32'h0, 0, 0);
        access(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0);
        access(1'b0, 1'b1, 3'd2, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 5, 0);
        // Load accepted at once but data never returns.
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h300;
        step();
        ex_valid = 1'b0; ex_load = 1'b0;
        n = 0;
        while (lsu_done !== 1'b1 && n < 20) begin step(); n++; end
        chk("to_ld_lat", 32'(n), 32'd8);
        chk("to_ld_code", 32'(lsu_err_code), 32'd3);
        chk("to_ld_rdata", lsu_rdata, 32'd0);
        step();
        mem_wait = 1'b1;
        ex_valid = 1'b1; ex_store = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h400;
        step();
        ex_valid = 1'b0; ex_store = 1'b0;
        n = 0;
        while (lsu_done !== 1'b1 && n < 20) begin step(); n++; end
        chk("to_st_lat", 32'(n), 32'd8);
        chk("to_st_code", 32'(lsu_err_code), 32'd3);
        chk("to_st_drop", 32'(mem_write), 32'd0);
        mem_wait = 1'b0;
        step();
        access(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'hBEEF_0000, 0, 0);
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h40;
        step();
        ex_valid = 1'b0; ex_load = 1'b0;
        step();
        chk("rst_pre_busy", 32'(lsu_busy), 32'd1);
        #2 iRST_n = 1'b0;
        #1;
        chk("arst_outs", 32'({lsu_busy, lsu_done, lsu_err, mem_read, mem_write}), 32'd0);
        chk("arst_rdata", lsu_rdata, 32'd0);
        step(); step();
        iRST_n = 1'b1;
        mem_rdata_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_rdata_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stray_rdv", 32'({lsu_done, lsu_busy}), 32'd0);
            chk("stray_rdata", lsu_rdata, 32'd0);
            step();
        end
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            ld  = sel == 0 ? 1'b1 : sel == 1 ? 1'b0 : sel[0];
            st  = sel == 0 ? 1'b1 : sel == 1 ? 1'b0 : !sel[0];
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            access(ld, st, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
RV32I load/store unit. It sits between the CPU execute stage and the Avalon memory interface stage.
- Turns LB/LH/LW/LBU/LHU/SB/SH/SW into single word-aligned memory requests with byte enables.
- Aligns and sign- or zero-extends load data.
- Flags misaligned accesses, illegal funct3 and memory timeouts, then returns one completion pulse to the CPU.

Parameters:
ADDR_W, 28, word-address width on the memory side (byte address bits [ADDR_W+1:2])
TIMEOUT_CYC, 1024, maximum cycles from request to completion; 0 disables the timeout
TO_W, 11, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
iCLK  in  1  clock
iRST_n  in  1  asynchronous active-low reset
ex_valid  in  1  CPU presents an access this cycle
ex_load  in  1  access is a load
ex_store  in  1  access is a store
ex_funct3  in  3  RV32I funct3
ex_addr  in  32  byte address
ex_wdata  in  32  store data (rs2)
lsu_busy  out  1  high while an access is in flight; ex_valid is ignored while high
lsu_done  out  1  one-cycle completion pulse
lsu_rdata  out  32  extended load result, valid with lsu_done
lsu_err  out  1  error flag, valid with lsu_done
lsu_err_code  out  2  0 none, 1 misaligned, 2 illegal op, 3 timeout
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  lane-replicated store data
mem_byteen  out  4  byte enables
mem_read  out  1  read request
mem_write  out  1  write request
mem_wait  in  1  memory stall; a request is accepted in a cycle where it is high and mem_wait is 0
mem_rdata_valid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Reset (async, iRST_n low):
  - state IDLE; all outputs 0; timeout counter 0.
  - Reset asserted mid-access abandons the access; no lsu_done is produced.
- States: IDLE, REQ, WAIT_RD, RESP.
- IDLE:
  - Capture on ex_valid: addr, funct3, load/store and data.
  - Legal access -> REQ. Error -> RESP with the error code; no memory request is issued.
  - lsu_busy goes high the cycle after capture.
- Illegal op (code 2):
  - ex_load and ex_store both set, or neither set;
  - load funct3 in {011,110,111};
  - store funct3 > 010.
- Misaligned (code 1):
  - H/HU/SH with addr[0]=1;
  - W/SW with addr[1:0]!=0.
  - Illegal op takes priority over misaligned.
- REQ:
  - Drive mem_addr=addr[ADDR_W+1:2], mem_byteen, mem_wdata, and mem_read or mem_write.
  - Hold all of them stable until accepted.
  - Accepted store -> RESP. Accepted load -> WAIT_RD.
- WAIT_RD: on mem_rdata_valid, latch the extracted and extended data -> RESP.
- RESP:
  - lsu_done=1 for exactly one cycle, with lsu_rdata and lsu_err / lsu_err_code.
  - lsu_busy=0 -> IDLE.
  - Earliest store completion: capture at T, request at T+1, lsu_done at T+2.
- Byte enables:
  - SB: 4'b0001<<addr[1:0]
  - SH: addr[1] ? 4'b1100 : 4'b0011
  - SW: 4'b1111
  - Reads also drive these enables.
- Write data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load extract:
  - Byte lane = rdata[8*addr[1:0]+:8]; halfword = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- lsu_rdata:
  - Stores and errors return 0.
  - It holds its value after the pulse until the next lsu_done.
- Timeout:
  - The counter clears on entering REQ and increments every cycle in REQ and WAIT_RD.
  - On reaching TIMEOUT_CYC with TIMEOUT_CYC != 0: drop requests -> RESP with code 3.
  - A mem_rdata_valid in the same cycle as the timeout wins: normal completion.
- Simultaneous and stray events:
  - mem_rdata_valid in IDLE, REQ or RESP is ignored.
  - mem_rdata_valid in the same cycle as acceptance of the read is not possible by protocol and is ignored.
  - ex_valid while busy is ignored, not queued.
- Never more than one outstanding access.

Decomposition:
- Package rv_lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - error code constants;
  - state encoding.
- Sub-module rv_lsu_align: combinational byte-enable / write-replicate generation and load extract/extend. It is reused by the future cache-fill path.

Test Plan:
- SB addr 0x103 wdata 0xAB -> mem_addr 0x40, byteen 1000, mem_wdata 0xABABABAB; lsu_done 2 cycles after capture with mem_wait=0.
- LB addr 0x102, mem_rdata 0x0080_0000 -> lsu_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102, rdata 0xBEEF0000 -> 0x0000BEEF.
- LW addr 0x202, then SH addr 0x001 -> both give lsu_done with err_code 1 one cycle after capture; mem_read and mem_write never assert.
- ex_load=ex_store=1 -> code 2. Load funct3=011 -> code 2.
- SW with mem_wait held high 5 cycles -> request signals stable for 6 cycles; done the cycle after acceptance.
- LW with rdata_valid never arriving, TIMEOUT_CYC=8 -> err_code 3 after 8 cycles.
- Async reset pulse in WAIT_RD -> outputs 0 immediately, no lsu_done; a stray later mem_rdata_valid is ignored.
